// File: rtl/vpu_pkg.sv
// Shared VPU types: operand width, lane delay width and the result-collector FSM state.
// Pure declarations; no logic.
package vpu_pkg;

  localparam int OPERAND_WIDTH = 32;
  localparam int MAX_DELAY_LG2 = 4;

  typedef enum logic {
    IDLE,
    WAIT
  } vpu_rc_state_t;

endpackage

// File: rtl/vpu_rc_fifo.sv
// Result buffer: register-array FIFO with registered head; data is visible the cycle after the push.
// Pop when empty is ignored; push when full is excluded upstream and flagged by an assertion.
module vpu_rc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_vld,
  output logic [WIDTH-1:0]         head_dat
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == CW'(DEPTH))));

endmodule

// File: rtl/vpu_result_collector.sv
// Collects one in-flight lane result per launch after delay_i cycles and queues it in a FIFO_DEPTH buffer.
// Launch refused while busy or buffer full; optional stall counter under VPU_RC_PERF_CNT_EN.
module vpu_result_collector
  import vpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [MAX_DELAY_LG2-1:0] delay_i,
  input  logic [OPERAND_WIDTH-1:0] lane_dout_i,
  output logic                     start_ready_o,
  output logic                     busy_o,
  output logic                     result_valid_o,
  output logic [OPERAND_WIDTH-1:0] result_o,
  input  logic                     result_ready_i,
  output logic [31:0]              perf_stall_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  vpu_rc_state_t            state, state_nxt;
  logic [MAX_DELAY_LG2-1:0] cnt, cnt_nxt;
  logic [CW-1:0]            fifo_count;
  logic                     push;
  logic                     accept;

  assign start_ready_o = (state == IDLE) && (fifo_count < DEPTH_C);
  assign accept        = start_i && start_ready_o;
  assign busy_o        = (state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter holds remaining cycles minus one, so the push lands on cycle T+D.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (delay_i == '0) begin
            push = 1'b1;
          end else begin
            cnt_nxt   = delay_i - MAX_DELAY_LG2'(1);
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - MAX_DELAY_LG2'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  vpu_rc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OPERAND_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (lane_dout_i),
    .pop      (result_ready_i),
    .count    (fifo_count),
    .head_vld (result_valid_o),
    .head_dat (result_o)
  );

`ifdef VPU_RC_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (result_valid_o && !result_ready_i && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vpu_result_collector.sv
// Directed bench for vpu_result_collector: per-cycle vector table plus hand-written corner sequences.
module tb_vpu_result_collector;
  import vpu_pkg::*;

  localparam int FIFO_DEPTH = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start_i;
  logic [MAX_DELAY_LG2-1:0] delay_i;
  logic [OPERAND_WIDTH-1:0] lane_dout_i;
  logic                     start_ready_o;
  logic                     busy_o;
  logic                     result_valid_o;
  logic [OPERAND_WIDTH-1:0] result_o;
  logic                     result_ready_i;
  logic [31:0]              perf_stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vpu_result_collector #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .delay_i          (delay_i),
    .lane_dout_i      (lane_dout_i),
    .start_ready_o    (start_ready_o),
    .busy_o           (busy_o),
    .result_valid_o   (result_valid_o),
    .result_o         (result_o),
    .result_ready_i   (result_ready_i),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  typedef struct {
    logic                     start;
    logic [MAX_DELAY_LG2-1:0] delay;
    logic [OPERAND_WIDTH-1:0] dout;
    logic                     rdy;
    logic                     exp_valid;
    logic [OPERAND_WIDTH-1:0] exp_result;
    logic                     exp_busy;
    logic                     exp_sr;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [MAX_DELAY_LG2-1:0] d,
                       input logic [OPERAND_WIDTH-1:0] dat, input logic r);
    start_i        = s;
    delay_i        = d;
    lane_dout_i    = dat;
    result_ready_i = r;
  endtask

  // Holds reset for two edges, checks reset values, releases; returns in the first cycle after release.
  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(result_valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_perf", perf_stall_cnt_o, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_start_ready", 32'(start_ready_o), 32'd1);
  endtask

  initial begin
    logic [31:0] perf_exp;

    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);

    // start, delay, dout, rdy | valid, result, busy, start_ready  (one row per cycle)
    vecs[0]  = '{1'b1, 4'd3, 32'h1234, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1};
    vecs[1]  = '{1'b0, 4'd0, 32'h1234, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'd0, 32'h1234, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'd0, 32'h1234, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'd0, 32'h0,    1'b1, 1'b1, 32'h1234, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 4'd0, 32'hA5,   1'b0, 1'b0, 32'h0,    1'b0, 1'b1};
    vecs[6]  = '{1'b0, 4'd0, 32'h0,    1'b0, 1'b1, 32'hA5,   1'b0, 1'b1};
    vecs[7]  = '{1'b1, 4'd0, 32'h77,   1'b1, 1'b1, 32'hA5,   1'b0, 1'b1};
    vecs[8]  = '{1'b0, 4'd0, 32'h0,    1'b1, 1'b1, 32'h77,   1'b0, 1'b1};
    vecs[9]  = '{1'b1, 4'd1, 32'h11,   1'b1, 1'b0, 32'h0,    1'b0, 1'b1};
    vecs[10] = '{1'b1, 4'd0, 32'h22,   1'b1, 1'b0, 32'h0,    1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'd0, 32'h0,    1'b0, 1'b1, 32'h22,   1'b0, 1'b1};
    vecs[12] = '{1'b0, 4'd0, 32'h0,    1'b1, 1'b1, 32'h22,   1'b0, 1'b1};
    vecs[13] = '{1'b0, 4'd0, 32'h0,    1'b1, 1'b0, 32'h0,    1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("vec%0d_valid", i), 32'(result_valid_o), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_result", i), result_o, vecs[i].exp_result);
      chk($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_start_ready", i), 32'(start_ready_o), 32'(vecs[i].exp_sr));
      drive(vecs[i].start, vecs[i].delay, vecs[i].dout, vecs[i].rdy);
      tick();
    end

    // Fill with ready low: third back-to-back start must be refused.
    do_reset();
    drive(1'b1, 4'd0, 32'd1, 1'b0);
    tick();
    chk("fill_sr_2nd", 32'(start_ready_o), 32'd1);
    chk("fill_head_1", result_o, 32'd1);
    drive(1'b1, 4'd0, 32'd2, 1'b0);
    tick();
    chk("fill_sr_3rd", 32'(start_ready_o), 32'd0);
    drive(1'b1, 4'd0, 32'd3, 1'b0);
    tick();
    drive(1'b0, 4'd0, 32'd0, 1'b1);
    chk("drain_valid_a", 32'(result_valid_o), 32'd1);
    chk("drain_head_1", result_o, 32'd1);
    tick();
    chk("drain_valid_b", 32'(result_valid_o), 32'd1);
    chk("drain_head_2", result_o, 32'd2);
    tick();
    chk("drain_empty", 32'(result_valid_o), 32'd0);

    // Steady push+pop at count 1 for 10 cycles keeps order.
    do_reset();
    drive(1'b1, 4'd0, 32'h100, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("pp%0d_valid", i), 32'(result_valid_o), 32'd1);
      chk($sformatf("pp%0d_head", i), result_o, 32'h100 + 32'(i));
      chk($sformatf("pp%0d_sr", i), 32'(start_ready_o), 32'd1);
      drive(1'b1, 4'd0, 32'h101 + 32'(i), 1'b1);
      tick();
    end
    drive(1'b0, 4'd0, 32'd0, 1'b1);
    chk("pp_last_head", result_o, 32'h10A);
    tick();
    chk("pp_end_empty", 32'(result_valid_o), 32'd0);

    // Reset in the middle of a delay-5 launch discards it.
    do_reset();
    drive(1'b1, 4'd5, 32'h99, 1'b1);
    tick();
    drive(1'b0, 4'd0, 32'h99, 1'b1);
    tick();
    rst = 1'b1;
    #2;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_sr", 32'(start_ready_o), 32'd1);
    chk("midrst_busy_after", 32'(busy_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("midrst_novalid%0d", i), 32'(result_valid_o), 32'd0);
      tick();
    end

    // Stall counter over 7 back-pressured cycles.
`ifdef VPU_RC_PERF_CNT_EN
    perf_exp = 32'd7;
`else
    perf_exp = 32'd0;
`endif
    do_reset();
    drive(1'b1, 4'd0, 32'h55, 1'b0);
    tick();
    drive(1'b0, 4'd0, 32'd0, 1'b0);
    chk("perf_valid", 32'(result_valid_o), 32'd1);
    repeat (7) tick();
    chk("perf_after7", perf_stall_cnt_o, perf_exp);
    result_ready_i = 1'b1;
    tick();
    chk("perf_hold", perf_stall_cnt_o, perf_exp);
    chk("perf_drained", 32'(result_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vpu_result_collector.md
VPU_RESULT_COLLECTOR -- requirements
Module: vpu_result_collector

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, result-buffer entries; SHALL be a power of two and at least 2.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port start_i  input  1  lane-launch pulse, issued in the same cycle as the lane's start.
REQ-005 Port delay_i  input  MAX_DELAY_LG2  lane latency for this launch, in cycles.
REQ-006 Port lane_dout_i  input  OPERAND_WIDTH  lane result bus; combinational from the lane.
REQ-007 Port start_ready_o  output  1  high when a start_i is accepted this cycle.
REQ-008 Port busy_o  output  1  high while a launch is in flight (state WAIT).
REQ-009 Port result_valid_o  output  1  head of the result buffer is valid.
REQ-010 Port result_o  output  OPERAND_WIDTH  head-of-buffer data.
REQ-011 Port result_ready_i  input  1  consumer accept; a pop occurs when valid and ready are both high.
REQ-012 Port perf_stall_cnt_o  output  32  back-pressure cycle count (see Configuration).

Function
REQ-013 FSM states SHALL be IDLE and WAIT; only one launch SHALL be in flight.
REQ-014 start_ready_o SHALL equal (state==IDLE) && (count<FIFO_DEPTH); a start_i while start_ready_o is low SHALL be ignored.
REQ-015 Accepted start with delay_i==0: lane_dout_i SHALL be pushed at the same edge, and the FSM SHALL stay IDLE.
REQ-016 Accepted start with delay_i==D>0: the counter SHALL load D-1 and the FSM SHALL go to WAIT.
REQ-017 In WAIT, the counter SHALL decrement each cycle. When it is 0, lane_dout_i SHALL be pushed at that edge and the FSM SHALL return to IDLE.
REQ-018 Net effect: start at cycle T with delay D pushes the lane_dout_i value present in cycle T+D. If the buffer was empty, result_valid_o SHALL rise in cycle T+D+1.
REQ-019 The buffer SHALL be FIFO-ordered; result_o SHALL be the registered head and stable while valid and not ready.
REQ-020 A simultaneous push and pop SHALL leave count unchanged and preserve order. This SHALL be legal at any count, including count==FIFO_DEPTH-1.
REQ-021 A push when full cannot occur by construction (REQ-014); an assertion SHALL flag it.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-023 A pop when empty SHALL be ignored.

Reset
REQ-024 While rst is high: state=IDLE, counter=0, pointers and count=0, result_valid_o=0, result_o=0, busy_o=0, perf_stall_cnt_o=0.
REQ-025 Reset asserted mid-WAIT SHALL discard the in-flight launch; no push SHALL occur after release.
REQ-026 start_ready_o SHALL be 1 in the first cycle after reset release.

Configuration
REQ-027 Macro VPU_RC_PERF_CNT_EN defined: perf_stall_cnt_o SHALL increment, saturating at 2^32-1, in each cycle where result_valid_o && !result_ready_i.
REQ-028 Macro VPU_RC_PERF_CNT_EN undefined: no counter flops SHALL exist and perf_stall_cnt_o SHALL be constant 0.

Structure
REQ-029 OPERAND_WIDTH and MAX_DELAY_LG2 SHALL come from VPU_PKG. A state enum typedef vpu_rc_state_t (IDLE, WAIT) SHALL be added to VPU_PKG.
REQ-030 Buffer storage SHALL be one sub-module, vpu_rc_fifo (parameterised depth/width, push/pop/count), instantiated once.

Verification
REQ-031 Scenario: start, delay=3, lane_dout=0x1234 held, ready=1 -> valid high exactly in cycle T+4 with result_o=0x1234, busy_o high in T+1..T+3.
REQ-032 Scenario: start, delay=0, lane_dout=0xA5 -> valid in T+1 with 0xA5, busy_o never high, start_ready_o high in T+1.
REQ-033 Scenario: ready=0, three back-to-back delay=0 starts, data 1,2,3 -> pushes 1 and 2; third start sees start_ready_o=0 and is dropped. Raise ready: pops 1 then 2, then valid falls.
REQ-034 Scenario: FIFO_DEPTH=2 with count=1, push and pop in the same cycle -> count stays 1, and order is preserved across 10 such cycles.
REQ-035 Scenario: start, delay=5, rst pulsed in T+2 -> no valid ever appears, and after release start_ready_o=1 and busy_o=0.
REQ-036 Scenario: with VPU_RC_PERF_CNT_EN defined, valid held 7 cycles with ready=0 -> perf_stall_cnt_o=7. Without the macro -> perf_stall_cnt_o=0.
